// File: rtl/btb_plru_nway.sv
// N-way set-associative BTB with tree-PLRU replacement,
// 2-bit direction counters and a one-set-per-cycle flush engine.
module btb_plru_nway #(
  parameter int SET_COUNT  = 16,
  parameter int N          = 8,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_stall_fetch,
  input  logic [ADDR_WIDTH-1:0]   i_pc,
  output logic                    o_hit,
  output logic                    o_predict_taken,
  output logic [ADDR_WIDTH-1:0]   o_target_addr,
  output logic [$clog2(N)-1:0]    o_way,
  input  logic                    i_update,
  input  logic                    i_update_taken,
  input  logic [ADDR_WIDTH-1:0]   i_update_pc,
  input  logic [ADDR_WIDTH-1:0]   i_update_target,
  input  logic [$clog2(N)-1:0]    i_update_way,
  input  logic                    i_flush,
  output logic                    o_flush_busy
);

  localparam int INDEX_W = $clog2(SET_COUNT);
  localparam int WAY_W   = $clog2(N);
  localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 2;
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SET_COUNT - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               state;
  logic [INDEX_W-1:0]   fl_cnt;
  logic [N-1:0]         valid [SET_COUNT];
  logic [1:0]           ctr   [SET_COUNT][N];
  logic [N-2:0]         plru  [SET_COUNT];
  logic [TAG_W-1:0]     tags  [SET_COUNT][N];
  logic [ADDR_WIDTH-1:0] tgts [SET_COUNT][N];

  function automatic logic [WAY_W-1:0] victim(
    input logic [N-2:0] b
  );
    logic [WAY_W-1:0] node;
    logic [WAY_W:0]   nxt;
    logic [WAY_W-1:0] w;
    logic             d;
    node = '0;
    w    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d    = b[node];
      w    = WAY_W'({w, d});
      nxt  = {node, 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(d);
      node = nxt[WAY_W-1:0];
    end
    return w;
  endfunction

  // Each node on the way's path is pointed at the other subtree.
  function automatic logic [N-2:0] touch(
    input logic [N-2:0]   b,
    input logic [WAY_W-1:0] w
  );
    logic [N-2:0]     r;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] ws;
    logic [WAY_W:0]   nxt;
    logic             d;
    r    = b;
    node = '0;
    ws   = w;
    for (int l = 0; l < WAY_W; l++) begin
      d       = ws[WAY_W-1];
      ws      = ws << 1;
      r[node] = ~d;
      nxt     = {node, 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(d);
      node    = nxt[WAY_W-1:0];
    end
    return r;
  endfunction

  logic               busy;
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [N-1:0]       lk_vec;
  logic [WAY_W-1:0]   lk_way;
  logic               lk_touch;

  assign busy   = (state == FLUSH);
  assign lk_idx = i_pc[INDEX_W+1:2];
  assign lk_tag = i_pc[ADDR_WIDTH-1:INDEX_W+2];

  always_comb begin
    lk_vec = '0;
    lk_way = '0;
    for (int w = 0; w < N; w++)
      lk_vec[w] = valid[lk_idx][w] && (tags[lk_idx][w] == lk_tag);
    for (int w = N - 1; w >= 0; w--)
      if (lk_vec[w]) lk_way = WAY_W'(w);
  end

  assign o_hit           = (|lk_vec) & ~busy;
  assign o_predict_taken = o_hit & ctr[lk_idx][lk_way][1];
  assign o_target_addr   = o_hit ? tgts[lk_idx][lk_way] : '0;
  assign o_way           = o_hit ? lk_way : victim(plru[lk_idx]);
  assign o_flush_busy    = busy;
  assign lk_touch        = o_hit & ~i_stall_fetch;

  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_match;
  logic               up_en;
  logic               up_touch;
  logic               up_ctr_we;
  logic [1:0]         up_ctr;
  logic [1:0]         up_ctr_nx;

  assign up_idx   = i_update_pc[INDEX_W+1:2];
  assign up_tag   = i_update_pc[ADDR_WIDTH-1:INDEX_W+2];
  assign up_match = valid[up_idx][i_update_way] &&
                    (tags[up_idx][i_update_way] == up_tag);
  assign up_en    = i_update & ~i_stall_fetch & ~busy & ~i_flush;
  assign up_touch = up_en & i_update_taken;
  assign up_ctr_we = up_en & (i_update_taken | up_match);
  assign up_ctr   = ctr[up_idx][i_update_way];

  always_comb begin
    up_ctr_nx = up_ctr;
    if (i_update_taken) begin
      if (!up_match)
        up_ctr_nx = 2'b10;
      else if (up_ctr != 2'b11)
        up_ctr_nx = up_ctr + 2'd1;
    end else if (up_ctr != 2'b00) begin
      up_ctr_nx = up_ctr - 2'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pc[1:0], i_update_pc[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state  <= IDLE;
      fl_cnt <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
        for (int w = 0; w < N; w++)
          ctr[s][w] <= 2'b00;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (lk_touch)
            plru[lk_idx] <= touch(plru[lk_idx], lk_way);
          // Same set: the later update touch overrides the lookup touch.
          if (up_touch)
            plru[up_idx] <= touch(plru[up_idx], i_update_way);
          if (up_touch)
            valid[up_idx][i_update_way] <= 1'b1;
          if (up_ctr_we)
            ctr[up_idx][i_update_way] <= up_ctr_nx;
          if (i_flush) begin
            state  <= FLUSH;
            fl_cnt <= '0;
          end
        end
        FLUSH: begin
          valid[fl_cnt] <= '0;
          plru[fl_cnt]  <= '0;
          fl_cnt        <= fl_cnt + 1'b1;
          if (fl_cnt == LAST_SET)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst && up_touch) begin
      tags[up_idx][i_update_way] <= up_tag;
      tgts[up_idx][i_update_way] <= i_update_target;
    end
  end

endmodule

// File: tb/tb_btb_plru_nway.sv
// Randomised and directed bench for btb_plru_nway (N=4, 16 sets)
// against a per-set array model of entries, counters and PLRU tree.
module tb_btb_plru_nway;

  localparam int SETS = 16;
  localparam int NW   = 4;
  localparam int AW   = 64;
  localparam int IW   = 4;
  localparam int WW   = 2;

  logic          clk = 1'b0;
  logic          rst, stall, upd, utk, flush;
  logic [AW-1:0] pc, upc, utgt;
  logic [WW-1:0] uway;
  logic          hit, ptk, busy;
  logic [AW-1:0] tgt;
  logic [WW-1:0] way;

  always #5 clk = ~clk;

  btb_plru_nway #(
    .SET_COUNT(SETS), .N(NW), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk), .i_arst(rst), .i_stall_fetch(stall),
    .i_pc(pc), .o_hit(hit), .o_predict_taken(ptk),
    .o_target_addr(tgt), .o_way(way),
    .i_update(upd), .i_update_taken(utk),
    .i_update_pc(upc), .i_update_target(utgt),
    .i_update_way(uway), .i_flush(flush),
    .o_flush_busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;

  bit            mv  [SETS][NW];
  logic [AW-1:0] mt  [SETS][NW];
  logic [AW-1:0] mtg [SETS][NW];
  int            mc  [SETS][NW];
  bit            mp  [SETS][NW-1];
  bit            mbusy;
  int            mcnt;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sidx(logic [AW-1:0] a);
    return int'(a[IW+1:2]);
  endfunction

  function automatic logic [AW-1:0] mkpc(int t, int s);
    return (AW'(t) << (IW + 2)) | (AW'(s) << 2);
  endfunction

  function automatic int mvictim(int s);
    int w = 0;
    for (int l = 0; l < WW; l++) begin
      int node = (1 << l) - 1 + w;
      w = 2 * w + int'(mp[s][node]);
    end
    return w;
  endfunction

  function automatic void mtouch(int s, int w);
    for (int l = 0; l < WW; l++) begin
      int node = (1 << l) - 1 + (w >> (WW - l));
      mp[s][node] = (((w >> (WW - 1 - l)) & 1) == 0);
    end
  endfunction

  function automatic int mfind(logic [AW-1:0] a);
    int s = sidx(a);
    for (int w = 0; w < NW; w++)
      if (mv[s][w] && mt[s][w] == (a >> (IW + 2))) return w;
    return -1;
  endfunction

  function automatic int mway(logic [AW-1:0] a);
    int f = mfind(a);
    return (f >= 0) ? f : mvictim(sidx(a));
  endfunction

  function automatic void mlook(input logic [AW-1:0] a, output bit h,
                                output int w, output logic [AW-1:0] t,
                                output bit k);
    int f = mfind(a);
    h = !mbusy && f >= 0;
    w = mway(a);
    t = h ? mtg[sidx(a)][f] : '0;
    k = h && mc[sidx(a)][f] >= 2;
  endfunction

  function automatic void model_edge();
    bit lh, lk, eff, utouch, match;
    int lw, ls, us, uw;
    logic [AW-1:0] lt;
    if (rst) begin
      foreach (mv[s, w]) begin mv[s][w] = 0; mc[s][w] = 0; end
      foreach (mp[s, n]) mp[s][n] = 0;
      mbusy = 0;
      mcnt = 0;
      return;
    end
    if (mbusy) begin
      for (int w = 0; w < NW; w++) mv[mcnt][w] = 0;
      for (int n = 0; n < NW - 1; n++) mp[mcnt][n] = 0;
      mcnt++;
      if (mcnt == SETS) mbusy = 0;
      return;
    end
    mlook(pc, lh, lw, lt, lk);
    ls = sidx(pc);
    us = sidx(upc);
    uw = int'(uway);
    eff = upd && !stall && !flush;
    utouch = eff && utk;
    match = mv[us][uw] && mt[us][uw] == (upc >> (IW + 2));
    if (lh && !stall && !(utouch && us == ls)) mtouch(ls, lw);
    if (eff && utk) begin
      mtg[us][uw] = utgt;
      if (match) mc[us][uw] = (mc[us][uw] < 3) ? mc[us][uw] + 1 : 3;
      else begin
        mv[us][uw] = 1;
        mt[us][uw] = upc >> (IW + 2);
        mc[us][uw] = 2;
      end
      mtouch(us, uw);
    end else if (eff && match) begin
      mc[us][uw] = (mc[us][uw] > 0) ? mc[us][uw] - 1 : 0;
    end
    if (flush) begin
      mbusy = 1;
      mcnt = 0;
    end
  endfunction

  task automatic tick();
    bit eh, ek;
    int ew;
    logic [AW-1:0] et;
    #1;
    if (armed) begin
      mlook(pc, eh, ew, et, ek);
      chk("hit", 64'(hit), 64'(eh));
      chk("taken", 64'(ptk), 64'(ek));
      chk("target", tgt, et);
      chk("busy", 64'(busy), 64'(mbusy));
      if (!mbusy) chk("way", 64'(way), 64'(ew));
    end
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rpc();
    return mkpc($urandom_range(0, 5), $urandom_range(0, 3)) |
           AW'($urandom_range(0, 3));
  endfunction

  int seq_w [4] = '{0, 2, 1, 3};
  int seq_v [4] = '{2, 1, -1, 0};
  int n;

  initial begin
    rst = 1; stall = 0; upd = 0; utk = 0; flush = 0;
    pc = '0; upc = '0; utgt = '0; uway = '0;
    tick();
    rst = 0;
    armed = 1;

    pc = 64'h1000;
    #1;
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_tgt", tgt, 64'd0);
    chk("rst_way", 64'(way), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_taken", 64'(ptk), 64'd0);
    upd = 1; utk = 1; upc = 64'h1000; utgt = 64'h2000; uway = 0;
    tick();
    upd = 0;
    #1;
    chk("first_hit", 64'(hit), 64'd1);
    chk("first_tgt", tgt, 64'h2000);
    chk("first_taken", 64'(ptk), 64'd1);
    tick();

    upd = 1; utk = 1;
    repeat (3) tick();
    utk = 0;
    repeat (3) tick();
    upd = 0;
    #1;
    chk("ctr_hit", 64'(hit), 64'd1);
    chk("ctr_low", 64'(ptk), 64'd0);
    tick();
    upd = 1; utk = 0;
    tick();
    utk = 1;
    tick();
    upd = 0;
    #1;
    chk("ctr_sat", 64'(ptk), 64'd0);
    tick();

    pc = mkpc(7777, 5);
    for (int i = 0; i < 4; i++) begin
      upd = 1; utk = 1; upc = mkpc(100 + i, 5);
      uway = WW'(seq_w[i]);
      tick();
      upd = 0;
      if (seq_v[i] >= 0) begin
        #1;
        chk("plru_vict", 64'(way), 64'(seq_v[i]));
      end
      tick();
    end

    for (int i = 0; i < NW; i++) begin
      upd = 1; utk = 1; upc = mkpc(200 + i, 3); uway = WW'(i);
      tick();
    end
    upd = 0; pc = mkpc(999, 3);
    #1;
    chk("fill_vict", 64'(way), 64'd0);
    tick();
    upd = 1; upc = mkpc(999, 3); uway = 0; utgt = 64'h3000;
    tick();
    upd = 0; pc = mkpc(200, 3);
    #1;
    chk("evict_old", 64'(hit), 64'd0);
    tick();
    pc = mkpc(999, 3);
    #1;
    chk("evict_new", 64'(hit), 64'd1);
    tick();

    pc = 64'h1000;
    flush = 1; upd = 1; utk = 1; upc = mkpc(300, 9); uway = 0;
    tick();
    flush = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      upd = 1; upc = mkpc(301 + i, 10);
      flush = (i == 3);
      #1;
      if (!busy) break;
      n++;
      tick();
    end
    upd = 0; flush = 0;
    chk("flush_len", 64'(n), 64'd16);
    tick();
    #1;
    chk("flush_old", 64'(hit), 64'd0);
    tick();
    pc = mkpc(300, 9);
    #1;
    chk("flush_drop", 64'(hit), 64'd0);
    tick();
    pc = mkpc(305, 10);
    #1;
    chk("busy_drop", 64'(hit), 64'd0);
    tick();

    upd = 1; utk = 1; upc = mkpc(400, 15); uway = 1;
    tick();
    upd = 0; pc = mkpc(400, 15);
    #1;
    chk("pre_hit", 64'(hit), 64'd1);
    tick();
    flush = 1;
    tick();
    flush = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hit", 64'(hit), 64'd0);
    tick();

    stall = 1; upd = 1; utk = 1; upc = mkpc(500, 2); uway = 1;
    pc = mkpc(500, 2);
    tick();
    stall = 0; upd = 0;
    #1;
    chk("stall_hit", 64'(hit), 64'd0);
    chk("stall_way", 64'(way), 64'd0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 5) == 0);
      pc    = rpc();
      upd   = ($urandom_range(0, 2) != 0);
      upc   = $urandom_range(0, 1) ? pc : rpc();
      utk   = ($urandom_range(0, 9) < 7);
      utgt  = {$urandom, $urandom};
      uway  = ($urandom_range(0, 3) != 0) ? WW'(mway(upc))
                                          : WW'($urandom_range(0, NW - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_plru_nway.md
Name: btb_plru_nway

Overview:
- Parametrised N-way set-associative branch target buffer with generalised tree-PLRU replacement, per-entry 2-bit direction counters and a sequential flush engine.
- Sits in the fetch stage. Lookup by fetch PC is combinational and same-cycle.
- Updates come from branch resolution, carrying back the way returned at lookup.

Parameters:
SET_COUNT, 16, number of sets; power of 2, >=2; INDEX_W = clog2(SET_COUNT)
N, 8, ways per set; power of 2, >=2; WAY_W = clog2(N)
ADDR_WIDTH, 64, PC/target width; TAG_W = ADDR_WIDTH - INDEX_W - 2

Ports:
i_clk  in  1  clock
i_arst  in  1  reset; synchronous, active-high
i_stall_fetch  in  1  blocks updates and PLRU touches when high
i_pc  in  ADDR_WIDTH  lookup PC; index = i_pc[INDEX_W+1:2], tag = i_pc[ADDR_WIDTH-1:INDEX_W+2]
o_hit  out  1  lookup hit
o_predict_taken  out  1  o_hit & counter[1] of the hit way
o_target_addr  out  ADDR_WIDTH  target of the hit way; 0 on miss
o_way  out  WAY_W  lowest hit way on hit, else PLRU victim of the lookup set
i_update  in  1  resolved-branch update strobe
i_update_taken  in  1  resolved direction
i_update_pc  in  ADDR_WIDTH  branch PC (index/tag split as for i_pc)
i_update_target  in  ADDR_WIDTH  resolved target
i_update_way  in  WAY_W  way returned by o_way at lookup
i_flush  in  1  start full invalidate
o_flush_busy  out  1  flush in progress

Behaviour:
- Reset (synchronous): all valid bits, PLRU bits and counters cleared; FSM to IDLE. Tag and target arrays are not reset.
- Reset outputs: o_hit=0, o_predict_taken=0, o_target_addr=0, o_way=0, o_flush_busy=0.
- Hit: way w hits when valid[w] is set and tag[w] equals the lookup tag. Multiple hits resolve to the lowest w.
- Tree PLRU, per set:
  - N-1 bits; node 0 is the root; node k has children 2k+1 and 2k+2. Bit 0 means the victim lies left.
  - Victim: walk from the root following the bits.
  - Touch way w: every node on w's path is set to point away from w.
- Update (effective when i_update & ~i_stall_fetch & FSM==IDLE & ~i_flush), entry E = [update index][i_update_way]:
  - Taken, E valid with tag match: store target; counter saturating +1.
  - Taken, otherwise: valid=1, store tag and target, counter=2'b10.
  - Taken, either case: touch the PLRU of E's set.
  - Not taken, E valid with tag match: counter saturating -1; entry stays valid; no PLRU change.
  - Not taken, otherwise: no effect.
- Lookup touch: o_hit & ~i_stall_fetch & IDLE touches the hit way of the lookup set. If an effective update hits the same set in the same cycle, the update's touch alone is applied. Different sets both apply.
- All writes land at the next rising edge; a lookup sees them the following cycle. There is no same-cycle bypass.
- Flush FSM, states IDLE and FLUSH:
  - IDLE & i_flush at edge k: go to FLUSH with set counter 0. An update in the same cycle is dropped.
  - In FLUSH, each edge clears valid and PLRU of set[counter] and increments the counter.
  - After clearing SET_COUNT-1, return to IDLE. o_flush_busy is high for exactly SET_COUNT cycles.
  - i_flush while in FLUSH is ignored.
  - While busy: o_hit=0, o_predict_taken=0, o_target_addr=0, updates dropped.
- Reset during a flush aborts it: IDLE next cycle, all arrays invalid.

Test Plan:
- After reset, lookup PC 0x1000 -> o_hit=0, o_target_addr=0, o_way=0. Update taken, way 0, target 0x2000 -> next-cycle lookup o_hit=1, o_target_addr=0x2000, o_predict_taken=1 (counter 10).
- Counter: three taken updates -> counter 11; three not-taken -> counter 00, o_hit=1, o_predict_taken=0; a fourth not-taken stays at 00.
- PLRU, N=4: touch way 0 -> victim way 2; touch way 2 -> victim way 1; touch ways 1, 3 -> victim way 0.
- Fill all N ways of set 3 with distinct tags, then a miss to set 3 -> o_way equals the PLRU victim. Update into it evicts the old tag; the old PC now misses.
- i_flush with SET_COUNT=16 -> o_flush_busy high 16 cycles, lookups miss throughout, concurrent updates dropped. Previously valid entries miss afterwards.
- Assert i_arst mid-flush at cycle 5 -> busy=0 next cycle; all lookups miss. Update with i_stall_fetch=1 -> no write, no PLRU change.
